// File: rtl/interface_demux.sv
`default_nettype none
// ============================================================================
// Module   : interface_demux
// Brief    : Switch-core egress distributor, shared queue -> four tx port FIFOs
// Revision : 1.0
// ============================================================================
module interface_demux #(
   parameter int TX_DATA_DEPTH = 4096
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ptr_sfifo_rd,
   input  logic [15:0] ptr_sfifo_dout,
   input  logic        ptr_sfifo_empty,
   output logic        sfifo_rd,
   input  logic [7:0]  sfifo_dout,
   output logic        tx_data_fifo_wr0,
   output logic        tx_data_fifo_wr1,
   output logic        tx_data_fifo_wr2,
   output logic        tx_data_fifo_wr3,
   output logic [7:0]  tx_data_fifo_din0,
   output logic [7:0]  tx_data_fifo_din1,
   output logic [7:0]  tx_data_fifo_din2,
   output logic [7:0]  tx_data_fifo_din3,
   input  logic [11:0] tx_data_fifo_cnt0,
   input  logic [11:0] tx_data_fifo_cnt1,
   input  logic [11:0] tx_data_fifo_cnt2,
   input  logic [11:0] tx_data_fifo_cnt3,
   output logic        tx_ptr_fifo_wr0,
   output logic        tx_ptr_fifo_wr1,
   output logic        tx_ptr_fifo_wr2,
   output logic        tx_ptr_fifo_wr3,
   output logic [15:0] tx_ptr_fifo_din0,
   output logic [15:0] tx_ptr_fifo_din1,
   output logic [15:0] tx_ptr_fifo_din2,
   output logic [15:0] tx_ptr_fifo_din3,
   input  logic        tx_ptr_fifo_full0,
   input  logic        tx_ptr_fifo_full1,
   input  logic        tx_ptr_fifo_full2,
   input  logic        tx_ptr_fifo_full3,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam logic [12:0] c_depth = 13'(TX_DATA_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PTR_RD  = 3'd1,
      S_PTR_CAP = 3'd2,
      S_CHECK   = 3'd3,
      S_XFER    = 3'd4,
      S_TAIL    = 3'd5,
      S_PTR_OUT = 3'd6,
      S_DRAIN   = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_desc;
   logic [10:0] r_remaining;
   logic        r_xfer_d;
   logic [15:0] r_frame_cnt;
   logic [15:0] r_drop_cnt;

   logic [3:0]        w_map;
   logic [10:0]       w_len;
   logic [3:0][11:0]  w_cnt;
   logic [3:0]        w_full;
   logic [3:0]        w_port_ok;
   logic [3:0]        w_data_wr;
   logic [3:0]        w_ptr_wr;
   logic [10:0]       w_cap_len;
   logic              w_last;

   assign w_map     = r_desc[14:11];
   assign w_len     = r_desc[10:0];
   assign w_cnt     = {tx_data_fifo_cnt3, tx_data_fifo_cnt2, tx_data_fifo_cnt1, tx_data_fifo_cnt0};
   assign w_full    = {tx_ptr_fifo_full3, tx_ptr_fifo_full2, tx_ptr_fifo_full1, tx_ptr_fifo_full0};
   assign w_cap_len = ptr_sfifo_dout[10:0];
   assign w_last    = (r_remaining == 11'd1);

   // Unselected ports never block; the sum is 13 bits so a nearly full FIFO cannot wrap.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_port_ok
         assign w_port_ok[i] = ~w_map[i] |
                               ((({1'b0, w_cnt[i]} + {2'b00, w_len}) <= c_depth) & ~w_full[i]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (!ptr_sfifo_empty) w_state_next = S_PTR_RD;
         S_PTR_RD:  w_state_next = S_PTR_CAP;
         S_PTR_CAP: begin
            if (w_cap_len == 11'd0)
               w_state_next = S_IDLE;
            else if (ptr_sfifo_dout[15] || (ptr_sfifo_dout[14:11] == 4'd0))
               w_state_next = S_DRAIN;
            else
               w_state_next = S_CHECK;
         end
         S_CHECK:   if (&w_port_ok) w_state_next = S_XFER;
         S_XFER:    if (w_last) w_state_next = S_TAIL;
         S_TAIL:    w_state_next = S_PTR_OUT;
         S_PTR_OUT: w_state_next = S_IDLE;
         S_DRAIN:   if (w_last) w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_desc      <= 16'd0;
         r_remaining <= 11'd0;
         r_xfer_d    <= 1'b0;
         r_frame_cnt <= 16'd0;
         r_drop_cnt  <= 16'd0;
      end else begin
         // Delayed read strobe lines up with the byte the standard-read FIFO presents next cycle.
         r_xfer_d <= (r_state == S_XFER);
         if (r_state == S_PTR_CAP) begin
            r_desc      <= {1'b0, ptr_sfifo_dout[14:0]};
            r_remaining <= w_cap_len;
         end else if ((r_state == S_XFER) || (r_state == S_DRAIN)) begin
            r_remaining <= r_remaining - 11'd1;
         end
         if (r_state == S_PTR_OUT)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         if (((r_state == S_PTR_CAP) && (w_cap_len == 11'd0)) ||
             ((r_state == S_DRAIN) && w_last))
            r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign ptr_sfifo_rd = (r_state == S_PTR_RD);
   assign sfifo_rd     = (r_state == S_XFER) || (r_state == S_DRAIN);
   assign w_data_wr    = {4{r_xfer_d}} & w_map;
   assign w_ptr_wr     = {4{r_state == S_PTR_OUT}} & w_map;

   assign tx_data_fifo_wr0  = w_data_wr[0];
   assign tx_data_fifo_wr1  = w_data_wr[1];
   assign tx_data_fifo_wr2  = w_data_wr[2];
   assign tx_data_fifo_wr3  = w_data_wr[3];
   assign tx_data_fifo_din0 = sfifo_dout;
   assign tx_data_fifo_din1 = sfifo_dout;
   assign tx_data_fifo_din2 = sfifo_dout;
   assign tx_data_fifo_din3 = sfifo_dout;
   assign tx_ptr_fifo_wr0   = w_ptr_wr[0];
   assign tx_ptr_fifo_wr1   = w_ptr_wr[1];
   assign tx_ptr_fifo_wr2   = w_ptr_wr[2];
   assign tx_ptr_fifo_wr3   = w_ptr_wr[3];
   assign tx_ptr_fifo_din0  = r_desc;
   assign tx_ptr_fifo_din1  = r_desc;
   assign tx_ptr_fifo_din2  = r_desc;
   assign tx_ptr_fifo_din3  = r_desc;
   assign frame_cnt         = r_frame_cnt;
   assign drop_cnt          = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/interface_demux.md
# interface_demux

Egress distributor of the switch core. It pops frame descriptors and payload bytes from the shared switch-core queue, which is a data FIFO plus a pointer FIFO. It then writes each frame into the per-port transmit data and pointer FIFOs of every port named in the descriptor's destination portmap. Multicast and broadcast frames are written to all selected ports in the same cycles. A frame starts only once every destination port can absorb the whole frame.

## Interface
Parameters:
- TX_DATA_DEPTH, 4096, capacity in bytes of each per-port tx data FIFO; used in the space check.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ptr_sfifo_rd  out  1  pop one descriptor from the shared pointer FIFO.
- ptr_sfifo_dout  in  16  descriptor: [15] error, [14:11] destination portmap (bit i = port i), [10:0] length in bytes.
- ptr_sfifo_empty  in  1  shared pointer FIFO empty.
- sfifo_rd  out  1  pop one byte from the shared data FIFO.
- sfifo_dout  in  8  shared data FIFO output byte.
- tx_data_fifo_wr0..3  out  1  per-port data write strobe.
- tx_data_fifo_din0..3  out  8  per-port data; all four equal sfifo_dout.
- tx_data_fifo_cnt0..3  in  12  per-port tx data FIFO occupancy in bytes.
- tx_ptr_fifo_wr0..3  out  1  per-port descriptor write strobe.
- tx_ptr_fifo_din0..3  out  16  per-port descriptor; all four carry the same registered value.
- tx_ptr_fifo_full0..3  in  1  per-port tx pointer FIFO full.
- frame_cnt  out  16  frames forwarded; wraps modulo 2^16.
- drop_cnt  out  16  frames discarded; wraps modulo 2^16.

## Operation
- Both shared FIFOs are standard-read FIFOs: dout is valid in the cycle after the rd cycle. At most one pop per cycle.
- State machine. Every state lasts one cycle unless noted.
  - IDLE: if ptr_sfifo_empty=0, go to PTR_RD.
  - PTR_RD: ptr_sfifo_rd=1.
  - PTR_CAP: latch map=dout[14:11], len=dout[10:0], err=dout[15].
    - If len=0, go to IDLE (counts as a drop).
    - Else if err=1 or map=0, go to DRAIN.
    - Else go to CHECK.
  - CHECK (≥1 cycle): for every i with map[i]=1, require cnt_i+len ≤ TX_DATA_DEPTH (13-bit compare) and tx_ptr_fifo_full_i=0. When all hold, go to XFER with remaining=len.
  - XFER (len cycles): sfifo_rd=1 and remaining decrements. When remaining reaches 1, go to TAIL.
  - TAIL: final data write lands in this cycle.
  - PTR_OUT: tx_ptr_fifo_wr_i=map[i]; frame_cnt increments; go to IDLE.
  - DRAIN (len cycles): sfifo_rd=1 with no tx writes. Then go to IDLE and increment drop_cnt.
- Data write path: tx_data_fifo_wr_i is sfifo_rd registered one cycle, ANDed with map[i]. tx_data_fifo_din_i = sfifo_dout with no register.
- Descriptor out is {1'b0, map, len}, registered in PTR_CAP.
- All strobe and rd outputs are decoded from registers only. There is no input-to-output combinational path except the din data path.
- CHECK is all-or-nothing. No port receives any byte until every destination has room. A blocked port stalls the whole queue; this head-of-line blocking is intended.

## Timing
- Reset values:
  - State: IDLE.
  - ptr_sfifo_rd, sfifo_rd, all tx wr strobes: 0.
  - tx_ptr_fifo_din*: 0.
  - frame_cnt, drop_cnt: 0.
- rst asserted at any point, including mid-XFER or mid-DRAIN: at the next edge all strobes are 0 and state is IDLE. The shared and tx FIFOs share rst, so partial frames are flushed with them.
- Forwarded frame of length L with space free: IDLE to IDLE is L+5 cycles.
  - First tx data write: 1 cycle after the first sfifo_rd.
  - Descriptor write: the cycle after TAIL.
- Descriptor write always follows the frame's last data write. The tx side never sees a descriptor before its data.
- Back-to-back frames: the next IDLE→PTR_RD happens in the cycle after PTR_OUT.
- Space is sampled only in CHECK. Occupancy changes during XFER are not rechecked, because tx FIFOs only drain during that time.
- Minimum len is 1 and maximum is 2047. Counters wrap from 0xFFFF to 0x0000.

## Test plan
- Unicast: descriptor 0x1040 (map 0010, L=64), bytes 0..63.
  - Port1: 64 data writes carrying bytes 0..63 in order, then one ptr write of 0x1040.
  - Ports 0, 2 and 3: no writes.
  - sfifo_rd high for exactly 64 cycles; frame_cnt=1; 69 cycles from IDLE back to IDLE.
- Broadcast: descriptor 0x783C (map 1111, L=60).
  - All four ports write identical bytes in the same cycles.
  - Four simultaneous ptr writes of 0x783C.
- Data backpressure: map 0100, L=8, cnt2=4090.
  - Stays in CHECK with no sfifo_rd.
  - Drop cnt2 to 4088: XFER starts the next cycle (4088+8=4096 passes).
- Pointer backpressure: map 1001, tx_ptr_fifo_full3=1.
  - No writes to port 0 or port 3.
  - Clear full3: both ports receive the frame simultaneously.
- Discard:
  - Descriptor 0x0064 (map 0, L=100): 100 sfifo_rd cycles, no tx writes, drop_cnt=1.
  - Descriptor 0x8864 (err=1): same response, drop_cnt=2.
- Reset after 10 bytes of XFER: next cycle all strobes 0, state IDLE, frame_cnt=0, drop_cnt=0; the next descriptor after reset is forwarded normally.
